// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO. The head entry is always visible on
// rd_data_o; when empty, wr_data_i is bypassed so a same-cycle write+read tunnels through.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             empty_o,
    output logic             full_o
);

    generate
        if (DEPTH == 1) begin : g_single
            logic             valid_q;
            logic             valid_d;
            logic             load_d;
            logic [WIDTH-1:0] data_q;

            // Holding: a read frees the slot and a simultaneous write refills it.
            // Empty: only a lone write loads; write+read tunnels and stores nothing.
            always_comb begin
                valid_d = valid_q;
                load_d  = 1'b0;
                if (valid_q) begin
                    if (rd_en_i) begin
                        valid_d = wr_en_i;
                        load_d  = wr_en_i;
                    end
                end else if (wr_en_i && !rd_en_i) begin
                    valid_d = 1'b1;
                    load_d  = 1'b1;
                end
            end

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    valid_q <= 1'b0;
                end else begin
                    valid_q <= valid_d;
                end
            end

            always_ff @(posedge clk_i) begin
                if (!rst_i && load_d) begin
                    data_q <= wr_data_i;
                end
            end

            assign rd_data_o = valid_q ? data_q : wr_data_i;
            assign empty_o   = !valid_q;
            assign full_o    = valid_q;
        end else begin : g_multi
            localparam int PW = $clog2(DEPTH);
            localparam int CW = $clog2(DEPTH + 1);

            logic [WIDTH-1:0] mem [DEPTH];
            logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
            logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
            logic [CW-1:0]    count_q,  count_d;
            logic             wr_acc;
            logic             rd_acc;
            logic             wr_store;

            // DEPTH may not be a power of two, so wrap on an explicit compare.
            function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
                return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
            endfunction

            assign empty_o = (count_q == '0);
            assign full_o  = (count_q == CW'(DEPTH));

            assign wr_acc   = wr_en_i && (!full_o || rd_en_i);
            assign rd_acc   = rd_en_i && !empty_o;
            // A tunnelled word is consumed through the bypass and never stored.
            assign wr_store = wr_acc && !(empty_o && rd_en_i);

            always_comb begin
                wr_ptr_d = wr_store ? ptr_inc(wr_ptr_q) : wr_ptr_q;
                rd_ptr_d = rd_acc   ? ptr_inc(rd_ptr_q) : rd_ptr_q;
                count_d  = count_q;
                if (wr_store && !rd_acc) begin
                    count_d = count_q + 1'b1;
                end else if (!wr_store && rd_acc) begin
                    count_d = count_q - 1'b1;
                end
            end

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                    count_q  <= '0;
                end else begin
                    wr_ptr_q <= wr_ptr_d;
                    rd_ptr_q <= rd_ptr_d;
                    count_q  <= count_d;
                end
            end

            // When full, wr_ptr equals rd_ptr, so a write+read overwrites the slot being popped.
            always_ff @(posedge clk_i) begin
                if (!rst_i && wr_store) begin
                    mem[wr_ptr_q] <= wr_data_i;
                end
            end

            assign rd_data_o = empty_o ? wr_data_i : mem[rd_ptr_q];
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo.sv
// Directed table-driven bench for sync_fifo at DEPTH 16, 1 and 5; each vector lists the
// inputs for one cycle and the outputs expected just before that cycle's rising edge.
module tb_sync_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst [3];
    logic       wr  [3];
    logic       rd  [3];
    logic [7:0] wd  [3];
    logic [7:0] rdd [3];
    logic       emp [3];
    logic       ful [3];

    sync_fifo #(.WIDTH(8), .DEPTH(16)) u_d16 (
        .clk_i(clk), .rst_i(rst[0]), .wr_en_i(wr[0]), .wr_data_i(wd[0]), .rd_en_i(rd[0]),
        .rd_data_o(rdd[0]), .empty_o(emp[0]), .full_o(ful[0])
    );
    sync_fifo #(.WIDTH(8), .DEPTH(1)) u_d1 (
        .clk_i(clk), .rst_i(rst[1]), .wr_en_i(wr[1]), .wr_data_i(wd[1]), .rd_en_i(rd[1]),
        .rd_data_o(rdd[1]), .empty_o(emp[1]), .full_o(ful[1])
    );
    sync_fifo #(.WIDTH(8), .DEPTH(5)) u_d5 (
        .clk_i(clk), .rst_i(rst[2]), .wr_en_i(wr[2]), .wr_data_i(wd[2]), .rd_en_i(rd[2]),
        .rd_data_o(rdd[2]), .empty_o(emp[2]), .full_o(ful[2])
    );

    typedef struct {
        logic       rst;
        logic       wr;
        logic [7:0] wd;
        logic       rd;
        logic [7:0] exp_d;
        logic       exp_e;
        logic       exp_f;
    } vec_t;

    vec_t vq[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic void add(bit r, bit w, logic [7:0] d, bit rdv,
                                logic [7:0] ed, bit ee, bit ef);
        vec_t v;
        v.rst = r; v.wr = w; v.wd = d; v.rd = rdv;
        v.exp_d = ed; v.exp_e = ee; v.exp_f = ef;
        vq.push_back(v);
    endfunction

    // Test plan for DEPTH >= 2: half fill, read a quarter, top up to full, drop, pop+push, drain.
    function automatic void build_generic(int d);
        int         h    = d / 2;
        int         r    = h / 2;
        int         fill = d - h + r;
        logic [7:0] drain[$];
        vq.delete();
        add(0, 0, 8'h00, 0, 8'h00, 1, 0);
        for (int i = 0; i < h; i++)    add(0, 1, 8'(8'h10 + i), 0, 8'h10, i == 0, 0);
        for (int i = 0; i < r; i++)    add(0, 0, 8'h00, 1, 8'(8'h10 + i), 0, 0);
        for (int i = 0; i < fill; i++) add(0, 1, 8'(8'h20 + i), 0, 8'(8'h10 + r), 0, 0);
        add(0, 1, 8'hAA, 0, 8'(8'h10 + r), 0, 1);
        add(0, 0, 8'h00, 0, 8'(8'h10 + r), 0, 1);
        add(0, 1, 8'hFF, 1, 8'(8'h10 + r), 0, 1);
        for (int i = r + 1; i < h; i++) drain.push_back(8'(8'h10 + i));
        for (int i = 0; i < fill; i++)  drain.push_back(8'(8'h20 + i));
        drain.push_back(8'hFF);
        for (int j = 0; j < drain.size(); j++) add(0, 0, 8'h00, 1, drain[j], 0, j == 0);
        add(0, 0, 8'h00, 1, 8'h00, 1, 0);
        add(0, 1, 8'h55, 1, 8'h55, 1, 0);
        add(0, 0, 8'h00, 0, 8'h00, 1, 0);
        add(0, 1, 8'h01, 0, 8'h01, 1, 0);
        add(0, 1, 8'h02, 1, 8'h01, 0, 0);
        add(0, 1, 8'h03, 0, 8'h02, 0, 0);
        add(0, 0, 8'h00, 1, 8'h02, 0, 0);
        add(0, 0, 8'h00, 0, 8'h03, 0, 0);
        add(0, 0, 8'h00, 1, 8'h03, 0, 0);
        add(0, 0, 8'h00, 0, 8'h00, 1, 0);
        add(0, 1, 8'h30, 0, 8'h30, 1, 0);
        add(0, 1, 8'h31, 0, 8'h30, 0, 0);
        add(0, 1, 8'h32, 0, 8'h30, 0, 0);
        add(1, 1, 8'h33, 0, 8'h30, 0, 0);
        add(0, 0, 8'h77, 0, 8'h77, 1, 0);
    endfunction

    function automatic void build_single();
        vq.delete();
        add(0, 0, 8'h00, 0, 8'h00, 1, 0);
        add(0, 1, 8'h10, 0, 8'h10, 1, 0);
        add(0, 1, 8'h11, 0, 8'h10, 0, 1);
        add(0, 0, 8'h00, 0, 8'h10, 0, 1);
        add(0, 1, 8'hFF, 1, 8'h10, 0, 1);
        add(0, 0, 8'h00, 0, 8'hFF, 0, 1);
        add(0, 0, 8'h00, 1, 8'hFF, 0, 1);
        add(0, 0, 8'h00, 1, 8'h00, 1, 0);
        add(0, 1, 8'h55, 1, 8'h55, 1, 0);
        add(0, 0, 8'h00, 0, 8'h00, 1, 0);
        add(0, 1, 8'h01, 0, 8'h01, 1, 0);
        add(0, 1, 8'h02, 1, 8'h01, 0, 1);
        add(0, 1, 8'h03, 0, 8'h02, 0, 1);
        add(0, 0, 8'h00, 1, 8'h02, 0, 1);
        add(0, 0, 8'h00, 0, 8'h00, 1, 0);
        add(0, 1, 8'h30, 0, 8'h30, 1, 0);
        add(1, 1, 8'h31, 0, 8'h30, 0, 1);
        add(0, 0, 8'h77, 0, 8'h77, 1, 0);
    endfunction

    task automatic check(string what, int dep, int idx, logic [7:0] got, logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s depth=%0d vec=%0d: got %h expected %h", what, dep, idx, got, exp);
        end
    endtask

    task automatic run(int k, int dep);
        for (int i = 0; i < vq.size(); i++) begin
            @(posedge clk);
            #1;
            rst[k] = vq[i].rst;
            wr[k]  = vq[i].wr;
            wd[k]  = vq[i].wd;
            rd[k]  = vq[i].rd;
            @(negedge clk);
            $display("depth=%0d vec=%0d rst=%0b wr=%0b wd=%h rd=%0b -> rd_data=%h empty=%0b full=%0b",
                     dep, i, vq[i].rst, vq[i].wr, vq[i].wd, vq[i].rd, rdd[k], emp[k], ful[k]);
            check("rd_data", dep, i, rdd[k], vq[i].exp_d);
            check("empty",   dep, i, {7'd0, emp[k]}, {7'd0, vq[i].exp_e});
            check("full",    dep, i, {7'd0, ful[k]}, {7'd0, vq[i].exp_f});
        end
        @(posedge clk);
        #1;
        wr[k] = 1'b0;
        rd[k] = 1'b0;
        rst[k] = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1;
            wr[k]  = 1'b0;
            rd[k]  = 1'b0;
            wd[k]  = 8'h00;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) rst[k] = 1'b0;

        build_generic(16);
        run(0, 16);
        build_single();
        run(1, 1);
        build_generic(5);
        run(2, 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
